// File: rtl/chime_scheduler.sv
// Buzzer arbiter: shares one tone generator between alarm, hourly chime and key beep.
// Priority alarm > chime > key; all outputs are registered from the next state.
module chime_scheduler #(
  parameter logic [19:0] CHIME_PERIOD    = 20'd191131,
  parameter logic [19:0] ALARM_PERIOD    = 20'd113636,
  parameter logic [19:0] KEY_PERIOD      = 20'd20000,
  parameter logic [23:0] KEY_CYCLES      = 24'd5000000,
  parameter logic [7:0]  ALARM_MAX_BEATS = 8'd60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        beat_tick,
  input  logic [5:0]  hour,
  input  logic        chime_req,
  input  logic        alarm_req,
  input  logic        alarm_stop,
  input  logic        key_req,
  output logic [19:0] tone_period,
  output logic        tone_on,
  output logic        busy,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    CHIME_ON,
    CHIME_OFF,
    ALARM_ON,
    ALARM_OFF
  } state_t;

  state_t      state, state_nx;
  logic [23:0] key_cnt, key_cnt_nx;
  logic [3:0]  strikes, strikes_nx;
  logic [7:0]  beat_cnt, beat_cnt_nx;
  logic [7:0]  beat_inc;
  logic        alarm_start;
  logic        chime_ok;
  logic [3:0]  chime_strikes;
  logic [19:0] period_nx;
  logic        on_nx;
  logic        busy_nx;
  logic [1:0]  grant_nx;

  // A simultaneous stop cancels the request, wherever it lands.
  assign alarm_start = alarm_req & ~alarm_stop;
  assign chime_ok    = chime_req & (hour <= 6'd23);
  assign beat_inc    = beat_cnt + 8'd1;

  always_comb begin
    chime_strikes = 4'(hour);
    if (hour == 6'd0 || hour == 6'd12)
      chime_strikes = 4'd12;
    else if (hour > 6'd12)
      chime_strikes = 4'(hour - 6'd12);
  end

  always_comb begin
    state_nx    = state;
    key_cnt_nx  = key_cnt;
    strikes_nx  = strikes;
    beat_cnt_nx = beat_cnt;

    if (!en) begin
      state_nx    = IDLE;
      key_cnt_nx  = '0;
      strikes_nx  = '0;
      beat_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (alarm_start) begin
            state_nx    = ALARM_ON;
            beat_cnt_nx = '0;
          end else if (chime_ok) begin
            state_nx   = CHIME_ON;
            strikes_nx = chime_strikes;
          end else if (key_req) begin
            state_nx   = KEY;
            key_cnt_nx = '0;
          end
        end

        KEY: begin
          if (alarm_start) begin
            state_nx    = ALARM_ON;
            beat_cnt_nx = '0;
            key_cnt_nx  = '0;
          end else if (key_cnt >= KEY_CYCLES - 24'd1) begin
            state_nx   = IDLE;
            key_cnt_nx = '0;
          end else begin
            key_cnt_nx = key_cnt + 24'd1;
          end
        end

        CHIME_ON: begin
          if (alarm_start) begin
            state_nx    = ALARM_ON;
            beat_cnt_nx = '0;
            strikes_nx  = '0;
          end else if (beat_tick) begin
            state_nx = CHIME_OFF;
          end
        end

        CHIME_OFF: begin
          if (alarm_start) begin
            state_nx    = ALARM_ON;
            beat_cnt_nx = '0;
            strikes_nx  = '0;
          end else if (beat_tick) begin
            if (strikes <= 4'd1) begin
              state_nx   = IDLE;
              strikes_nx = '0;
            end else begin
              state_nx   = CHIME_ON;
              strikes_nx = strikes - 4'd1;
            end
          end
        end

        ALARM_ON, ALARM_OFF: begin
          if (alarm_stop) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
          end else if (beat_tick) begin
            if (beat_inc >= ALARM_MAX_BEATS) begin
              state_nx    = IDLE;
              beat_cnt_nx = '0;
            end else begin
              beat_cnt_nx = beat_inc;
              state_nx    = (state == ALARM_ON) ? ALARM_OFF : ALARM_ON;
            end
          end
        end

        default: begin
          state_nx    = IDLE;
          key_cnt_nx  = '0;
          strikes_nx  = '0;
          beat_cnt_nx = '0;
        end
      endcase
    end

    period_nx = '0;
    on_nx     = 1'b0;
    busy_nx   = (state_nx != IDLE);
    grant_nx  = 2'b00;
    case (state_nx)
      KEY: begin
        period_nx = KEY_PERIOD;
        on_nx     = 1'b1;
        grant_nx  = 2'b01;
      end
      CHIME_ON: begin
        period_nx = CHIME_PERIOD;
        on_nx     = 1'b1;
        grant_nx  = 2'b10;
      end
      CHIME_OFF: grant_nx = 2'b10;
      ALARM_ON: begin
        period_nx = ALARM_PERIOD;
        on_nx     = 1'b1;
        grant_nx  = 2'b11;
      end
      ALARM_OFF: grant_nx = 2'b11;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_cnt     <= '0;
      strikes     <= '0;
      beat_cnt    <= '0;
      tone_period <= '0;
      tone_on     <= 1'b0;
      busy        <= 1'b0;
      grant       <= 2'b00;
    end else begin
      state       <= state_nx;
      key_cnt     <= key_cnt_nx;
      strikes     <= strikes_nx;
      beat_cnt    <= beat_cnt_nx;
      tone_period <= period_nx;
      tone_on     <= on_nx;
      busy        <= busy_nx;
      grant       <= grant_nx;
    end
  end

endmodule

// File: tb/tb_chime_scheduler.sv
// Directed-vector bench for chime_scheduler with shortened key beep and alarm timeout.
module tb_chime_scheduler;

  localparam logic [19:0] P_CHIME = 20'd191131;
  localparam logic [19:0] P_ALARM = 20'd113636;
  localparam logic [19:0] P_KEY   = 20'd20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        beat_tick;
  logic [5:0]  hour;
  logic        chime_req;
  logic        alarm_req;
  logic        alarm_stop;
  logic        key_req;
  logic [19:0] tone_period;
  logic        tone_on;
  logic        busy;
  logic [1:0]  grant;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  chime_scheduler #(
    .KEY_CYCLES      (24'd8),
    .ALARM_MAX_BEATS (8'd6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .beat_tick   (beat_tick),
    .hour        (hour),
    .chime_req   (chime_req),
    .alarm_req   (alarm_req),
    .alarm_stop  (alarm_stop),
    .key_req     (key_req),
    .tone_period (tone_period),
    .tone_on     (tone_on),
    .busy        (busy),
    .grant       (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output invariants, sampled away from the active edge.
  always @(negedge clk) begin
    chk("inv_period", 32'(tone_period != 20'd0), 32'(tone_on));
    chk("inv_grant", 32'(grant != 2'b00), 32'(busy));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat();
    beat_tick = 1'b1;
    cycle();
    beat_tick = 1'b0;
    repeat (9) cycle();
  endtask

  task automatic run_chime(input logic [5:0] h, input int unsigned n);
    int unsigned beats;
    int unsigned ons;
    logic prev;
    hour = h;
    chime_req = 1'b1;
    cycle();
    chime_req = 1'b0;
    chk("chime_grant", 32'(grant), 32'(2'b10));
    chk("chime_period", 32'(tone_period), 32'(P_CHIME));
    beats = 0;
    ons = 1;
    prev = 1'b1;
    while (busy && beats < 60) begin
      beat();
      beats++;
      if (tone_on && !prev) ons++;
      prev = tone_on;
    end
    chk("chime_beats", beats, 2 * n);
    chk("chime_strikes", ons, n);
  endtask

  initial begin
    int unsigned on_len;
    rst_n = 1'b0; en = 1'b1; beat_tick = 1'b0; hour = '0;
    chime_req = 1'b0; alarm_req = 1'b0; alarm_stop = 1'b0; key_req = 1'b0;
    repeat (2) cycle();
    chk("rst_period", 32'(tone_period), 0);
    chk("rst_on", 32'(tone_on), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    rst_n = 1'b1;
    cycle();

    // Chime strike counts, including the 0 and 12 wrap and an out-of-range hour.
    run_chime(6'd15, 3);
    run_chime(6'd0, 12);
    run_chime(6'd12, 12);
    hour = 6'd30;
    chime_req = 1'b1;
    cycle();
    chime_req = 1'b0;
    chk("bad_hour_busy", 32'(busy), 0);
    chk("bad_hour_on", 32'(tone_on), 0);

    // Key beep length, with a second press mid-beep.
    key_req = 1'b1;
    cycle();
    key_req = 1'b0;
    chk("key_grant", 32'(grant), 32'(2'b01));
    chk("key_period", 32'(tone_period), 32'(P_KEY));
    on_len = 1;
    for (int i = 0; i < 50; i++) begin
      if (i == 3) key_req = 1'b1;
      cycle();
      key_req = 1'b0;
      if (!tone_on) break;
      on_len++;
    end
    chk("key_len", on_len, 8);
    chk("key_done_busy", 32'(busy), 0);

    // Alarm preempts a chime at strike 2; stop silences it and the chime stays dead.
    hour = 6'd9;
    chime_req = 1'b1;
    cycle();
    chime_req = 1'b0;
    beat();
    chk("c9_off", 32'(tone_on), 0);
    beat();
    chk("c9_strike2", 32'(tone_on), 1);
    alarm_req = 1'b1;
    cycle();
    alarm_req = 1'b0;
    chk("preempt_grant", 32'(grant), 32'(2'b11));
    chk("preempt_period", 32'(tone_period), 32'(P_ALARM));
    alarm_stop = 1'b1;
    cycle();
    alarm_stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_on", 32'(tone_on), 0);
    beat();
    beat();
    chk("no_resume", 32'(busy), 0);

    // Alarm timeout after 6 beats; a repeat request mid-alarm must not restart the count.
    alarm_req = 1'b1;
    cycle();
    alarm_req = 1'b0;
    chk("alarm_grant", 32'(grant), 32'(2'b11));
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) begin
        alarm_req = 1'b1;
        cycle();
        alarm_req = 1'b0;
      end
      beat();
      chk("alarm_on", 32'(tone_on), 32'((i % 2 == 0) && (i < 6)));
      chk("alarm_busy", 32'(busy), 32'(i < 6));
    end

    hour = 6'd5;
    alarm_req = 1'b1; chime_req = 1'b1; key_req = 1'b1;
    cycle();
    alarm_req = 1'b0; chime_req = 1'b0; key_req = 1'b0;
    chk("simul_grant", 32'(grant), 32'(2'b11));
    alarm_stop = 1'b1;
    cycle();
    alarm_stop = 1'b0;
    chk("simul_stop", 32'(busy), 0);
    alarm_stop = 1'b1;
    cycle();
    alarm_stop = 1'b0;
    chk("idle_stop", 32'(busy), 0);
    alarm_req = 1'b1; alarm_stop = 1'b1;
    cycle();
    alarm_req = 1'b0; alarm_stop = 1'b0;
    chk("stop_wins", 32'(busy), 0);

    // Master enable drop, then asynchronous reset mid-chime.
    alarm_req = 1'b1;
    cycle();
    alarm_req = 1'b0;
    chk("en_pre_on", 32'(tone_on), 1);
    en = 1'b0;
    cycle();
    chk("en_off_on", 32'(tone_on), 0);
    chk("en_off_grant", 32'(grant), 0);
    chk("en_off_period", 32'(tone_period), 0);
    key_req = 1'b1;
    cycle();
    key_req = 1'b0;
    chk("en_off_key", 32'(busy), 0);
    en = 1'b1;
    cycle();

    hour = 6'd3;
    chime_req = 1'b1;
    cycle();
    chime_req = 1'b0;
    chk("pre_rst_on", 32'(tone_on), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_on", 32'(tone_on), 0);
    chk("arst_period", 32'(tone_period), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_grant", 32'(grant), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
